qa_drv_prim_tag_pool: RTL

//  Initiator-side tag manager, the counterpart of the ordered-return scoreboard.

---
 rtl/qa_drv_prim_pkg.sv | 20 ++
 rtl/qa_drv_prim_dualport_ram.sv | 37 +++
 rtl/qa_drv_prim_tag_pool.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/qa_drv_prim_pkg.sv
// Shared types for the qa_drv_prim tag-pool family: pool FSM states and sized tag types.
package qa_drv_prim_pkg;

    localparam int unsigned TAG_POOL_N_TAGS = 32;
    localparam int unsigned TAG_POOL_TAG_W  = $clog2(TAG_POOL_N_TAGS);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } t_TAG_POOL_STATE;

    // Tag index, and tag pointer with one extra wrap bit
    typedef logic [TAG_POOL_TAG_W-1:0] t_TAG;
    typedef logic [TAG_POOL_TAG_W:0]   t_TAG_NOWRAP;

    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/qa_drv_prim_dualport_ram.sv
// Simple 1W/1R RAM: port 0 writes, port 1 reads with a registered output.
module qa_drv_prim_dualport_ram #(
    parameter  int unsigned DEPTH = 32,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Port 0 write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Port 1 registered read; a same-address write in this cycle is not visible yet
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/qa_drv_prim_tag_pool.sv
// Initiator-side tag pool: FIFO free ring of tags, per-tag in-use bits and meta-data storage.
module qa_drv_prim_tag_pool
    import qa_drv_prim_pkg::*;
#(
    parameter  int unsigned N_TAGS        = TAG_POOL_N_TAGS,
    parameter  int unsigned N_META_BITS   = 16,
    parameter  int unsigned MIN_FREE_TAGS = 1,
    localparam int unsigned TAG_W         = $clog2(N_TAGS)
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   alloc_en,
    input  logic [N_META_BITS-1:0] allocMeta,
    output logic                   allocRdy,
    output logic [TAG_W-1:0]       allocTag,
    input  logic                   free_en,
    input  logic [TAG_W-1:0]       freeTag,
    input  logic [TAG_W-1:0]       lookupTag,
    output logic [N_META_BITS-1:0] lookupMeta,
    output logic [TAG_W:0]         numFree
);

    if (!is_pow2(N_TAGS) || (N_TAGS < 4)) begin : g_bad_n_tags
        $fatal(1, "N_TAGS must be a power of 2 and at least 4");
    end
    if (N_TAGS != TAG_POOL_N_TAGS) begin : g_bad_pkg_width
        $fatal(1, "N_TAGS must match the tag width of qa_drv_prim_pkg");
    end

    t_TAG_POOL_STATE   r_state;
    t_TAG_POOL_STATE   w_state_next;
    t_TAG              r_ring [N_TAGS];
    t_TAG_NOWRAP       r_head;
    t_TAG_NOWRAP       r_tail;
    t_TAG_NOWRAP       r_num_free;
    t_TAG              r_init_tag;
    logic [N_TAGS-1:0] r_in_use;
    logic [N_TAGS-1:0] w_in_use_next;
    logic              w_init_wr;
    logic              w_ring_wr;
    t_TAG              w_ring_wr_tag;
    t_TAG              w_alloc_tag;

    // State register
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: INIT seeds one tag per cycle, then hands over to READY
    always_comb begin
        w_state_next = r_state;
        w_init_wr    = 1'b0;
        case (r_state)
            INIT: begin
                w_init_wr = 1'b1;
                if (r_init_tag == t_TAG'(N_TAGS - 1)) begin
                    w_state_next = READY;
                end
            end
            READY: begin
                w_state_next = READY;
            end
        endcase
    end

    // Ring write source: seeding during INIT, released tags afterwards
    always_comb begin
        w_ring_wr     = w_init_wr | free_en;
        w_ring_wr_tag = w_init_wr ? r_init_tag : t_TAG'(freeTag);
    end

    // In-use tracking; an allocation overrides a free of the same tag
    always_comb begin
        w_in_use_next = r_in_use;
        if (free_en) begin
            w_in_use_next[freeTag] = 1'b0;
        end
        if (alloc_en) begin
            w_in_use_next[w_alloc_tag] = 1'b1;
        end
    end

    // Free ring storage; stale entries are harmless because INIT rewrites every slot
    always_ff @(posedge clk) begin
        if (w_ring_wr) begin
            r_ring[r_tail[TAG_W-1:0]] <= w_ring_wr_tag;
        end
    end

    // Pointers, free count, seed counter and in-use vector
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_num_free <= '0;
            r_init_tag <= '0;
            r_in_use   <= '0;
        end else begin
            if (w_init_wr) begin
                r_init_tag <= r_init_tag + t_TAG'(1);
            end
            if (w_ring_wr) begin
                r_tail <= r_tail + t_TAG_NOWRAP'(1);
            end
            if (alloc_en) begin
                r_head <= r_head + t_TAG_NOWRAP'(1);
            end
            r_num_free <= r_num_free + t_TAG_NOWRAP'(w_ring_wr) - t_TAG_NOWRAP'(alloc_en);
            r_in_use   <= w_in_use_next;
        end
    end

    assign w_alloc_tag = r_ring[r_head[TAG_W-1:0]];
    assign allocTag    = w_alloc_tag;
    assign allocRdy    = (r_state == READY) && (r_num_free >= t_TAG_NOWRAP'(MIN_FREE_TAGS));
    assign numFree     = r_num_free;

    // Meta-data: written at the granted tag, read back by lookup
    qa_drv_prim_dualport_ram #(
        .DEPTH (N_TAGS),
        .WIDTH (N_META_BITS)
    ) u_meta_ram (
        .clk       (clk),
        .resetb    (resetb),
        .i_wr_en   (alloc_en),
        .i_wr_addr (w_alloc_tag),
        .i_wr_data (allocMeta),
        .i_rd_addr (lookupTag),
        .o_rd_data (lookupMeta)
    );

    // Handshake protocol checks
    always_ff @(posedge clk) begin
        if (resetb) begin
            assert (!(alloc_en && !allocRdy))
                else $fatal(1, "alloc_en while allocRdy is low");
            assert (!(free_en && !r_in_use[freeTag]))
                else $fatal(1, "free_en for a tag that is not in use");
            assert (!(free_en && (r_num_free == t_TAG_NOWRAP'(N_TAGS))))
                else $fatal(1, "free_en while every tag is already free");
            assert (!((r_state == INIT) && (alloc_en || free_en)))
                else $fatal(1, "handshake during INIT");
        end
    end

endmodule
